pwm_capture: RTL

PWM/heartbeat receiver: measures the period and high time of an asynchronous PWM input in clk cycles.
It is the capture end of the counter-driven PWM/heartbeat outputs, used to check the duty and period of PWM/LED drive signals on the board or in loopback.
It reports one measurement per full input period, with a one-cycle valid strobe, and flags loss of toggling (0 % / 100 % duty or a dead line).

---
 rtl/pwm_pkg.sv | 14 +
 rtl/sync_edge_detect.sv | 34 +++
 rtl/pwm_capture.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator and capture blocks: FSM state
// encoding and default counter/synchronizer sizing.
package pwm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } pwm_state_e;

    localparam int PWM_CNT_W       = 20;
    localparam int PWM_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous level input plus a history flop
// that yields single-cycle rise/fall strobes in the clk domain.
module sync_edge_detect
    import pwm_pkg::*;
#(
    parameter int SYNC_STAGES = PWM_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic s_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // sync_q[0] is the metastability-exposed stage; the last stage is clean.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s_o    = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM/heartbeat receiver: measures period and high time of an asynchronous
// PWM input in clk cycles and flags loss of toggling.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W       = PWM_CNT_W,
    parameter int SYNC_STAGES = PWM_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic s;
    logic rise;
    logic fall;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .reset  (reset),
        .async_i(pwm_in),
        .s_o    (s),
        .rise_o (rise),
        .fall_o (fall)
    );

    pwm_state_e       state_q, state_d;
    logic [CNT_W-1:0] r_cnt_q, r_cnt_d;
    logic [CNT_W-1:0] h_lat_q, h_lat_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             mv_q, mv_d;
    logic             to_q, to_d;
    logic             sat;

    assign sat = (r_cnt_q == CNT_MAX);

    always_comb begin
        state_d  = state_q;
        r_cnt_d  = r_cnt_q;
        h_lat_d  = h_lat_q;
        period_d = period_q;
        high_d   = high_q;
        mv_d     = 1'b0;
        to_d     = to_q;

        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            if (state_q != ST_IDLE && !sat) begin
                r_cnt_d = r_cnt_q + CNT_ONE;
            end
            // A rise restarts the interval from any state, including IDLE.
            if (rise) begin
                r_cnt_d = CNT_ONE;
                to_d    = 1'b0;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_d = ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
                        state_d = ST_LOW;
                        h_lat_d = r_cnt_q;
                    end else if (sat && s && !rise) begin
                        state_d = ST_IDLE;
                        to_d    = 1'b1;
                    end
                end
                ST_LOW: begin
                    // Rise beats saturation: a full-scale period still reports.
                    if (rise) begin
                        state_d  = ST_HIGH;
                        period_d = r_cnt_q;
                        high_d   = h_lat_q;
                        mv_d     = 1'b1;
                    end else if (sat && !s) begin
                        state_d = ST_IDLE;
                        to_d    = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            r_cnt_q  <= '0;
            h_lat_q  <= '0;
            period_q <= '0;
            high_q   <= '0;
            mv_q     <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_cnt_q  <= r_cnt_d;
            h_lat_q  <= h_lat_d;
            period_q <= period_d;
            high_q   <= high_d;
            mv_q     <= mv_d;
            to_q     <= to_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign meas_valid = mv_q;
    assign timeout    = to_q;

endmodule
